ssd_rx_monitor: RTL

Receive-side counterpart to the seven-segment display drivers. It samples a 7-bit active-low segment bus (segment a at bit 0, g at bit 6, 0 = lit) and debounces it with a stability filter. Each accepted pattern is decoded back to a 4-bit digit. The block then checks that successive digits form an incrementing sequence and measures the clock-cycle period between digit changes. It sits beside a counter/display path as a self-check and bring-up monitor.

---
 rtl/ssd_pkg.sv | 30 +++
 rtl/ssd_stable_filter.sv | 41 ++++
 rtl/ssd_rx_monitor.sv | 109 ++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared seven-segment encoding, decode helper and monitor state type.
// Patterns are active-low with segment a in the leftmost (index 0) position.
package ssd_pkg;

    localparam int SEG_W = 7;

    typedef logic [0:SEG_W-1] seg_t;

    localparam seg_t SSD_BLANK = 7'b1111111;

    localparam seg_t SSD_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {S_FIRST, S_TRACK} state_t;

    // Returns {hit, value}; hit is 0 for any pattern outside the table.
    function automatic logic [4:0] ssd_decode(input seg_t p);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (p == SSD_TABLE[i]) r = {1'b1, i[3:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/ssd_stable_filter.sv
// ssd_stable_filter: synchronizes the segment bus and emits a one-cycle stable
// pulse once a pattern has held for STABLE_CYCLES consecutive samples.
module ssd_stable_filter
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  seg_t ssd_i,
    output logic stable_o,
    output seg_t pattern_o
);

    seg_t       meta_q;
    seg_t       cand_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // The second synchronizer stage doubles as the candidate; the counter
    // holds (samples held - 1) and parks at all-ones so each hold pulses once.
    always_comb begin
        cnt_d = (meta_q != cand_q) ? 8'd0 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= SSD_BLANK;
            cand_q <= SSD_BLANK;
            cnt_q  <= 8'hFF;
        end else begin
            meta_q <= ssd_i;
            cand_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

    assign stable_o  = (cnt_q == 8'(STABLE_CYCLES - 1));
    assign pattern_o = cand_q;

endmodule

// File: rtl/ssd_rx_monitor.sv
// ssd_rx_monitor: decodes debounced segment patterns back to digits, checks
// that they increment and measures the period between digit changes.
module ssd_rx_monitor
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 26,
    parameter int MODE_DEC      = 1
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [0:6]          SSD,
    input  logic                CLR,
    output logic [3:0]          DIGIT,
    output logic                DIGIT_VALID,
    output logic                BLANK,
    output logic                INVALID,
    output logic                SEQ_ERR,
    output logic [PERIOD_W-1:0] PERIOD,
    output logic [15:0]         CHANGE_CNT
);

    logic stable;
    seg_t pat;

    ssd_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk_i     (CLOCK_50),
        .rst_ni    (RESET_N),
        .ssd_i     (SSD),
        .stable_o  (stable),
        .pattern_o (pat)
    );

    state_t              state_q, state_d;
    seg_t                last_q, last_d;
    logic                chk_q, chk_d;
    logic                ref_q, ref_d;
    logic [PERIOD_W-1:0] gap_q, gap_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [3:0]          digit_q, digit_d;
    logic                dv_q, dv_d, blank_q, blank_d, inv_q, inv_d, seq_q, seq_d;

    logic       accept, hit, is_dig, is_blank, is_inv;
    logic [3:0] val, nxt;
    logic [4:0] inc;

    always_comb begin
        accept   = stable && (state_q == S_FIRST || pat != last_q);
        {hit, val} = ssd_decode(pat);
        is_dig   = accept && hit;
        is_blank = accept && !hit && pat == SSD_BLANK;
        is_inv   = accept && !hit && pat != SSD_BLANK;
        inc      = {1'b0, digit_q} + 5'd1;
        nxt      = (MODE_DEC != 0 && inc >= 5'd10) ? 4'(inc - 5'd10) : inc[3:0];
        state_d  = accept ? S_TRACK : CLR ? S_FIRST : state_q;
        last_d   = accept ? pat : last_q;
        // chk: next digit is sequence-checked; ref: a prior digit exists to time from
        chk_d    = is_dig ? 1'b1 : (accept || CLR) ? 1'b0 : chk_q;
        ref_d    = is_dig ? 1'b1 : CLR ? 1'b0 : ref_q;
        gap_d    = (is_dig || CLR) ? '0 : (&gap_q) ? gap_q : gap_q + 1'b1;
        period_d = CLR ? '0 : (is_dig && ref_q) ? ((&gap_q) ? gap_q : gap_q + 1'b1) : period_q;
        cnt_d    = CLR ? 16'd0 : (is_dig && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        digit_d  = is_dig ? val : digit_q;
        dv_d     = is_dig;
        blank_d  = is_dig ? 1'b0 : is_blank ? 1'b1 : blank_q;
        inv_d    = is_inv;
        seq_d    = is_dig && chk_q && !CLR && val != nxt;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_FIRST;
            last_q   <= SSD_BLANK;
            chk_q    <= 1'b0;
            ref_q    <= 1'b0;
            gap_q    <= '0;
            period_q <= '0;
            cnt_q    <= 16'd0;
            digit_q  <= 4'd0;
            dv_q     <= 1'b0;
            blank_q  <= 1'b0;
            inv_q    <= 1'b0;
            seq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            chk_q    <= chk_d;
            ref_q    <= ref_d;
            gap_q    <= gap_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            dv_q     <= dv_d;
            blank_q  <= blank_d;
            inv_q    <= inv_d;
            seq_q    <= seq_d;
        end
    end

    assign DIGIT       = digit_q;
    assign DIGIT_VALID = dv_q;
    assign BLANK       = blank_q;
    assign INVALID     = inv_q;
    assign SEQ_ERR     = seq_q;
    assign PERIOD      = period_q;
    assign CHANGE_CNT  = cnt_q;

endmodule
